// File: rtl/storage_arb_pkg.sv
// -----------------------------------------------------------------------------
// storage_arb_pkg
// Shared definitions for the matrix-storage arbiter: owner encoding,
// requester bit positions in the request vector, default parameters and a
// helper that turns an owner code into a one-hot requester mask.
// Optional feature macro used by this slice: STORAGE_ARB_RR_EN (round-robin
// picker instead of fixed priority).
// -----------------------------------------------------------------------------
package storage_arb_pkg;

  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned MAX_BURST_DEF = 16;

  // Bit positions of each requester inside the 3-bit request vector
  localparam int unsigned IDX_IN   = 0;
  localparam int unsigned IDX_DISP = 1;
  localparam int unsigned IDX_CALC = 2;
  localparam int unsigned NUM_REQ  = 3;

  // Owner encoding, also exported on the debug/LED port
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IN   = 2'd1,
    OWN_DISP = 2'd2,
    OWN_CALC = 2'd3
  } owner_e;

  // One-hot requester mask of an owner code (zero for OWN_NONE)
  function automatic logic [NUM_REQ-1:0] owner_mask(input owner_e o);
    logic [NUM_REQ-1:0] m;
    m = 3'b000;
    case (o)
      OWN_IN:   m[IDX_IN]   = 1'b1;
      OWN_DISP: m[IDX_DISP] = 1'b1;
      OWN_CALC: m[IDX_CALC] = 1'b1;
      default:  m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/storage_arbiter_picker.sv
// -----------------------------------------------------------------------------
// arb_picker
// Combinational 3-way winner selection for the storage arbiter.
//   req_i  [2:0] request vector (bit order per storage_arb_pkg IDX_*)
//   excl_i [2:0] requesters that may not win this pick
//   last_i       most recent owner (only used by the round-robin variant)
//   win_o        winning owner code, OWN_NONE when nobody is eligible
// Macro STORAGE_ARB_RR_EN: defined selects round-robin (most recent owner
// lowest, calc > input > display after reset); undefined selects fixed
// priority calc > input > display.
// -----------------------------------------------------------------------------
module arb_picker
  import storage_arb_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [2:0] excl_i,
  input  owner_e     last_i,
  output owner_e     win_o
);

  logic [2:0] elig_s;

  assign elig_s = req_i & ~excl_i;

  // First eligible requester in the order a > b > c
  function automatic owner_e prio_pick(input logic [2:0] elig,
                                       input owner_e a,
                                       input owner_e b,
                                       input owner_e c);
    owner_e w;
    if ((elig & owner_mask(a)) != 3'b000) begin
      w = a;
    end else if ((elig & owner_mask(b)) != 3'b000) begin
      w = b;
    end else if ((elig & owner_mask(c)) != 3'b000) begin
      w = c;
    end else begin
      w = OWN_NONE;
    end
    return w;
  endfunction

`ifdef STORAGE_ARB_RR_EN
  // Rotate priority so the most recent owner comes last; no history
  // (OWN_NONE) behaves like "display was last", giving calc > input > display.
  always_comb begin
    win_o = OWN_NONE;
    case (last_i)
      OWN_CALC: win_o = prio_pick(elig_s, OWN_IN, OWN_DISP, OWN_CALC);
      OWN_IN:   win_o = prio_pick(elig_s, OWN_DISP, OWN_CALC, OWN_IN);
      default:  win_o = prio_pick(elig_s, OWN_CALC, OWN_IN, OWN_DISP);
    endcase
  end
`else
  logic unused_last_s;
  assign unused_last_s = ^last_i;

  // Fixed priority; fairness comes from the caller excluding a
  // force-released owner
  always_comb begin
    win_o = OWN_NONE;
    win_o = prio_pick(elig_s, OWN_CALC, OWN_IN, OWN_DISP);
  end
`endif

endmodule

// File: rtl/storage_arbiter.sv
// -----------------------------------------------------------------------------
// storage_arbiter
// Shares the single-port 256x32 matrix storage (1-cycle synchronous read)
// between the input, display and calculator subsystems using a per-requester
// req/gnt handshake, bursts bounded by MAX_BURST and tagged read return.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_/we_/addr_/wdata_{in,disp,calc}   requester side inputs
//   gnt_{in,disp,calc}             one-hot grant (decoded from owner register)
//   rvalid_{in,disp,calc}          read data valid for that requester
//   rdata                          storage read data broadcast
//   mem_addr/mem_we/mem_wdata      storage side, driven only on an access beat
//   mem_rdata                      storage read data
//   owner                          0 none, 1 input, 2 display, 3 calc
// Macro STORAGE_ARB_RR_EN selects the round-robin picker (see arb_picker).
// -----------------------------------------------------------------------------
module storage_arbiter
  import storage_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic              req_disp,
  input  logic              req_calc,
  input  logic              we_in,
  input  logic              we_disp,
  input  logic              we_calc,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [ADDR_W-1:0] addr_disp,
  input  logic [ADDR_W-1:0] addr_calc,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] wdata_disp,
  input  logic [DATA_W-1:0] wdata_calc,
  output logic              gnt_in,
  output logic              gnt_disp,
  output logic              gnt_calc,
  output logic              rvalid_in,
  output logic              rvalid_disp,
  output logic              rvalid_calc,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  owner_e              pick_s, pick_last_s;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic [2:0]          rvalid_q, rvalid_d;
  logic [2:0]          req_vec_s, own_mask_s;
  logic                own_req_s, own_we_s, beat_s, others_pend_s;
  logic [ADDR_W-1:0]   own_addr_s;
  logic [DATA_W-1:0]   own_wdata_s;

  assign req_vec_s[IDX_IN]   = req_in;
  assign req_vec_s[IDX_DISP] = req_disp;
  assign req_vec_s[IDX_CALC] = req_calc;

  assign own_mask_s    = owner_mask(owner_q);
  assign others_pend_s = (req_vec_s & ~own_mask_s) != 3'b000;
  // Round-robin history: the current owner while owning, else the last one
  assign pick_last_s   = (owner_q != OWN_NONE) ? owner_q : last_q;

  // The current owner is always excluded, so a pick made while owning only
  // ever hands over; in IDLE the mask is empty.
  arb_picker u_picker (
    .req_i  (req_vec_s),
    .excl_i (own_mask_s),
    .last_i (pick_last_s),
    .win_o  (pick_s)
  );

  // Select the owner's request-side signals
  always_comb begin
    own_req_s   = 1'b0;
    own_we_s    = 1'b0;
    own_addr_s  = {ADDR_W{1'b0}};
    own_wdata_s = {DATA_W{1'b0}};
    case (owner_q)
      OWN_IN: begin
        own_req_s   = req_in;
        own_we_s    = we_in;
        own_addr_s  = addr_in;
        own_wdata_s = wdata_in;
      end
      OWN_DISP: begin
        own_req_s   = req_disp;
        own_we_s    = we_disp;
        own_addr_s  = addr_disp;
        own_wdata_s = wdata_disp;
      end
      OWN_CALC: begin
        own_req_s   = req_calc;
        own_we_s    = we_calc;
        own_addr_s  = addr_calc;
        own_wdata_s = wdata_calc;
      end
      default: begin
        own_req_s   = 1'b0;
        own_we_s    = 1'b0;
        own_addr_s  = {ADDR_W{1'b0}};
        own_wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Owner's req is zero in IDLE, so this is gnt & req of the owner
  assign beat_s = own_req_s;

  // Storage port is quiet (all zero) outside an access beat
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = {DATA_W{1'b0}};
    if (beat_s) begin
      mem_addr  = own_addr_s;
      mem_we    = own_we_s;
      mem_wdata = own_wdata_s;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_we    = 1'b0;
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Next owner, burst counter and round-robin history
  always_comb begin
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    last_d     = (owner_q != OWN_NONE) ? owner_q : last_q;
    case (owner_q)
      OWN_NONE: begin
        beat_cnt_d = 8'd0;
        if (req_vec_s != 3'b000) begin
          owner_d = pick_s;
        end else begin
          owner_d = OWN_NONE;
        end
      end
      default: begin
        if (!own_req_s) begin
          // Owner finished: hand over (dead cycle is this one) or go idle
          beat_cnt_d = 8'd0;
          owner_d    = others_pend_s ? pick_s : OWN_NONE;
        end else if (beat_cnt_q == BURST_LAST) begin
          // Burst limit: release only if someone else is waiting
          beat_cnt_d = 8'd0;
          owner_d    = others_pend_s ? pick_s : owner_q;
        end else begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          owner_d    = owner_q;
        end
      end
    endcase
  end

  // Read return is tagged with the owner of the read beat, so it survives
  // a grant change on the following edge
  always_comb begin
    rvalid_d = 3'b000;
    if (beat_s && !own_we_s) begin
      rvalid_d = own_mask_s;
    end else begin
      rvalid_d = 3'b000;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      last_q     <= OWN_NONE;
      beat_cnt_q <= 8'd0;
      rvalid_q   <= 3'b000;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign gnt_in   = (owner_q == OWN_IN);
  assign gnt_disp = (owner_q == OWN_DISP);
  assign gnt_calc = (owner_q == OWN_CALC);

  // A read in flight when reset arrives is dropped, including the cycle
  // in which reset is asserted
  assign rvalid_in   = rvalid_q[IDX_IN]   & ~rst;
  assign rvalid_disp = rvalid_q[IDX_DISP] & ~rst;
  assign rvalid_calc = rvalid_q[IDX_CALC] & ~rst;

  assign rdata = mem_rdata;
  assign owner = owner_q;

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter: vector table plus multi-cycle sequences.
module tb_storage_arbiter;

  logic        clk;
  logic        rst;
  logic        req_in, req_disp, req_calc;
  logic        we_in, we_disp, we_calc;
  logic [7:0]  addr_in, addr_disp, addr_calc;
  logic [31:0] wdata_in, wdata_disp, wdata_calc;
  logic        gnt_in, gnt_disp, gnt_calc;
  logic        rvalid_in, rvalid_disp, rvalid_calc;
  logic [31:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  owner;

  storage_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .req_disp(req_disp), .req_calc(req_calc),
    .we_in(we_in), .we_disp(we_disp), .we_calc(we_calc),
    .addr_in(addr_in), .addr_disp(addr_disp), .addr_calc(addr_calc),
    .wdata_in(wdata_in), .wdata_disp(wdata_disp), .wdata_calc(wdata_calc),
    .gnt_in(gnt_in), .gnt_disp(gnt_disp), .gnt_calc(gnt_calc),
    .rvalid_in(rvalid_in), .rvalid_disp(rvalid_disp), .rvalid_calc(rvalid_calc),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage model: unwritten words read back as C0FFEE_<addr>
  logic [31:0]  mem [0:255];
  logic [255:0] wr_valid;
  always @(posedge clk) begin
    if (rst) begin
      wr_valid <= '0;
    end else if (mem_we) begin
      mem[mem_addr]      <= mem_wdata;
      wr_valid[mem_addr] <= 1'b1;
    end
    mem_rdata <= wr_valid[mem_addr] ? mem[mem_addr] : {24'hC0FFEE, mem_addr};
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  req;   // {calc, disp, in}
    logic [2:0]  we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [2:0]  gnt;
    logic [2:0]  rv;
    logic [1:0]  own;
    logic        mwe;
    logic [7:0]  maddr;
    logic        rchk;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(logic r, logic [2:0] rq, logic [2:0] w, logic [7:0] a,
                              logic [31:0] d, logic c, logic [2:0] g, logic [2:0] v,
                              logic [1:0] o, logic mw, logic [7:0] ma, logic rc,
                              logic [31:0] rd);
    vec_t t;
    t.rst = r; t.req = rq; t.we = w; t.addr = a; t.wdata = d; t.chk = c;
    t.gnt = g; t.rv = v; t.own = o; t.mwe = mw; t.maddr = ma; t.rchk = rc; t.rdata = rd;
    return t;
  endfunction

  vec_t vecs [0:12];

  // sequence bookkeeping
  int calc_done, disp_done, calc_first, first_disp_cyc, calc16_cyc, last_disp_cyc, gap;
  int rv_calc_n, rv_disp_n, rv_err, rd_err, idle_after, nseg;
  logic seen_disp, prev_bc, prev_bd, bc, bd, got;
  logic [7:0] prev_addr;
  logic [1:0] seg_own [0:7];
  int         seg_len [0:7];
  logic [1:0] exp_own [0:3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {req_in, req_disp, req_calc} = 3'b000;
    {we_in, we_disp, we_calc} = 3'b000;
    addr_in = 8'h00; addr_disp = 8'h00; addr_calc = 8'h00;
    wdata_in = 32'h0; wdata_disp = 32'h0; wdata_calc = 32'h0;

    //            rst req     we      addr   wdata          chk gnt    rv     own mwe ma     rchk rdata
    vecs[0]  = mk(1'b1, 3'b000, 3'b000, 8'h00, 32'h0,        1'b0, 3'b000, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 3'b000, 3'b000, 8'h00, 32'h0,        1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 3'b100, 3'b100, 8'h10, 32'h1234,     1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 32'h0);
    vecs[3]  = mk(1'b0, 3'b100, 3'b100, 8'h10, 32'h1234,     1'b1, 3'b100, 3'b000, 2'd3, 1'b1, 8'h10, 1'b0, 32'h0);
    vecs[4]  = mk(1'b0, 3'b100, 3'b000, 8'h10, 32'h0,        1'b1, 3'b100, 3'b000, 2'd3, 1'b0, 8'h10, 1'b0, 32'h0);
    vecs[5]  = mk(1'b0, 3'b000, 3'b000, 8'h10, 32'h0,        1'b1, 3'b100, 3'b100, 2'd3, 1'b0, 8'h00, 1'b1, 32'h1234);
    vecs[6]  = mk(1'b0, 3'b000, 3'b000, 8'h00, 32'h0,        1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 3'b011, 3'b000, 8'h05, 32'h0,        1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 32'h0);
    vecs[8]  = mk(1'b0, 3'b011, 3'b001, 8'h05, 32'h55,       1'b1, 3'b001, 3'b000, 2'd1, 1'b1, 8'h25, 1'b0, 32'h0);
    vecs[9]  = mk(1'b0, 3'b010, 3'b000, 8'h05, 32'h0,        1'b1, 3'b001, 3'b000, 2'd1, 1'b0, 8'h00, 1'b0, 32'h0);
    vecs[10] = mk(1'b0, 3'b010, 3'b000, 8'h65, 32'h0,        1'b1, 3'b010, 3'b000, 2'd2, 1'b0, 8'h25, 1'b0, 32'h0);
    vecs[11] = mk(1'b0, 3'b000, 3'b000, 8'h00, 32'h0,        1'b1, 3'b010, 3'b010, 2'd2, 1'b0, 8'h00, 1'b1, 32'hA0000055);
    vecs[12] = mk(1'b0, 3'b000, 3'b000, 8'h00, 32'h0,        1'b1, 3'b000, 3'b000, 2'd0, 1'b0, 8'h00, 1'b0, 32'h0);

    tick();
    // ---------------- vector table ----------------
    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst;
      {req_calc, req_disp, req_in} = vecs[i].req;
      {we_calc, we_disp, we_in} = vecs[i].we;
      addr_calc  = vecs[i].addr;
      addr_in    = vecs[i].addr ^ 8'h20;
      addr_disp  = vecs[i].addr ^ 8'h40;
      wdata_calc = vecs[i].wdata;
      wdata_in   = vecs[i].wdata ^ 32'hA0000000;
      wdata_disp = vecs[i].wdata ^ 32'h0B000000;
      @(negedge clk);
      if (vecs[i].chk) begin
        chk($sformatf("row%0d gnt/rv/own/mwe/maddr", i),
            {15'd0, gnt_calc, gnt_disp, gnt_in, rvalid_calc, rvalid_disp, rvalid_in, owner, mem_we, mem_addr},
            {15'd0, vecs[i].gnt, vecs[i].rv, vecs[i].own, vecs[i].mwe, vecs[i].maddr});
      end
      if (vecs[i].rchk) chk($sformatf("row%0d rdata", i), rdata, vecs[i].rdata);
      tick();
    end

    // ---------------- burst limit: calc 40 reads vs display 3 reads ----------------
    calc_done = 0; disp_done = 0; calc_first = 0; first_disp_cyc = -1; calc16_cyc = -1;
    last_disp_cyc = -1; gap = -1; rv_calc_n = 0; rv_disp_n = 0; rv_err = 0; rd_err = 0;
    seen_disp = 1'b0; prev_bc = 1'b0; prev_bd = 1'b0; prev_addr = 8'h00;
    {we_in, we_disp, we_calc} = 3'b000;
    req_in = 1'b0; addr_in = 8'h00;
    for (int c = 0; c < 55; c++) begin
      req_calc  = (calc_done < 40);
      addr_calc = 8'h80 + 8'(calc_done);
      req_disp  = (disp_done < 3);
      addr_disp = 8'hC0 + 8'(disp_done);
      @(negedge clk);
      bc = gnt_calc & req_calc;
      bd = gnt_disp & req_disp;
      if (rvalid_calc !== prev_bc || rvalid_disp !== prev_bd) rv_err++;
      if (rvalid_calc) rv_calc_n++;
      if (rvalid_disp) rv_disp_n++;
      if ((rvalid_calc || rvalid_disp) && rdata !== {24'hC0FFEE, prev_addr}) rd_err++;
      if (bc) begin
        calc_done++;
        if (!seen_disp) calc_first++;
        if (calc_done == 16) calc16_cyc = c;
        if (seen_disp && disp_done == 3 && gap < 0) gap = c - last_disp_cyc;
      end
      if (bd) begin
        if (!seen_disp) first_disp_cyc = c;
        seen_disp = 1'b1;
        disp_done++;
        last_disp_cyc = c;
      end
      prev_bc = bc;
      prev_bd = bd;
      prev_addr = bc ? addr_calc : addr_disp;
      tick();
    end
    @(negedge clk);
    chk("burst calc first run", calc_first, 16);
    chk("burst disp follows at once", first_disp_cyc, calc16_cyc + 1);
    chk("burst disp beats", disp_done, 3);
    chk("burst calc regain gap", gap, 2);
    chk("burst calc total beats", calc_done, 40);
    chk("burst rvalid_calc count", rv_calc_n, 40);
    chk("burst rvalid_disp count", rv_disp_n, 3);
    chk("burst rvalid timing errors", rv_err, 0);
    chk("burst rdata errors", rd_err, 0);
    chk("burst idle at end", owner, 2'd0);
    tick();

    // ---------------- idle: storage port stays quiet ----------------
    {we_in, we_disp, we_calc} = 3'b111;
    addr_in = 8'h33; addr_disp = 8'h44; addr_calc = 8'h55;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d own/mwe/maddr", c), {21'd0, owner, mem_we, mem_addr}, 32'd0);
      tick();
    end
    {we_in, we_disp, we_calc} = 3'b000;

    // ---------------- reset right after a read beat ----------------
    req_calc = 1'b1; addr_calc = 8'h90; got = 1'b0;
    for (int k = 0; k < 5 && !got; k++) begin
      @(negedge clk);
      if (gnt_calc) got = 1'b1;
      else tick();
    end
    chk("rst seq grant", got, 1'b1);
    tick();
    rst = 1'b1; req_calc = 1'b0;
    @(negedge clk);
    chk("rst seq rvalid during rst", {rvalid_calc, rvalid_disp, rvalid_in}, 3'b000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst seq own/gnt/rv after", {owner, gnt_calc, gnt_disp, gnt_in, rvalid_calc, rvalid_disp, rvalid_in}, 8'd0);
    tick();

    // ---------------- all three requesting continuously ----------------
`ifdef STORAGE_ARB_RR_EN
    exp_own[0] = 2'd3; exp_own[1] = 2'd1; exp_own[2] = 2'd2; exp_own[3] = 2'd3;
`else
    exp_own[0] = 2'd3; exp_own[1] = 2'd1; exp_own[2] = 2'd3; exp_own[3] = 2'd1;
`endif
    for (int s = 0; s < 8; s++) begin
      seg_own[s] = 2'd0;
      seg_len[s] = 0;
    end
    nseg = 0; idle_after = 0;
    {req_in, req_disp, req_calc} = 3'b111;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (owner != 2'd0) begin
        if (nseg == 0 || seg_own[nseg-1] != owner) begin
          if (nseg < 8) begin
            seg_own[nseg] = owner;
            seg_len[nseg] = 1;
            nseg++;
          end
        end else begin
          seg_len[nseg-1]++;
        end
      end else if (nseg > 0) begin
        idle_after++;
      end
      tick();
    end
    {req_in, req_disp, req_calc} = 3'b000;
    chk("rotate segment count>=4", (nseg >= 4), 1'b1);
    for (int s = 0; s < 4; s++) chk($sformatf("rotate seg%0d owner", s), seg_own[s], exp_own[s]);
    for (int s = 0; s < 3; s++) chk($sformatf("rotate seg%0d length", s), seg_len[s], 16);
    chk("rotate no dead cycles", idle_after, 0);
    tick();
    @(negedge clk);
    chk("rotate idle after release", owner, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
